// File: rtl/counter_sched.sv
// Round-robin command scheduler for an external 32-bit counter: grants requester A or B,
// then preloads the counter, runs it for LEN enabled cycles, captures the result and acknowledges.
module counter_sched #(
    parameter int LEN_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ_A,
    input  logic             REQ_B,
    input  logic [1:0]       MODO_A,
    input  logic [1:0]       MODO_B,
    input  logic [31:0]      D_A,
    input  logic [31:0]      D_B,
    input  logic [LEN_W-1:0] LEN_A,
    input  logic [LEN_W-1:0] LEN_B,
    input  logic [31:0]      CNT_Q,
    input  logic             CNT_RCO,
    output logic             CNT_ENABLE,
    output logic [1:0]       CNT_MODO,
    output logic [31:0]      CNT_D,
    output logic             ACK_A,
    output logic             ACK_B,
    output logic             BUSY,
    output logic             GNT,
    output logic [31:0]      RESULT,
    output logic             OVF
);

    typedef enum logic [2:0] {
        IDLE,
        PRELOAD,
        RUN,
        SETTLE,
        DONE
    } state_t;

    localparam logic [1:0]       MODE_LOAD = 2'b11;
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [31:0]      dval_q, dval_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             gnt_q, gnt_d;
    logic             prio_b_q, prio_b_d;
    logic             blk_a_q, blk_a_d;
    logic             blk_b_q, blk_b_d;
    logic [31:0]      result_q, result_d;
    logic             ovf_q, ovf_d;

    logic elig_a, elig_b, pick_b;

    assign elig_a = REQ_A && !blk_a_q;
    assign elig_b = REQ_B && !blk_b_q;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        dval_d     = dval_q;
        len_d      = len_q;
        gnt_d      = gnt_q;
        prio_b_d   = prio_b_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        blk_a_d    = 1'b0;
        blk_b_d    = 1'b0;
        pick_b     = 1'b0;
        CNT_ENABLE = 1'b0;
        CNT_MODO   = 2'b00;

        case (state_q)
            IDLE: begin
                if (elig_a || elig_b) begin
                    // B wins only when alone or when it holds the round-robin priority
                    pick_b   = elig_b && (!elig_a || prio_b_q);
                    gnt_d    = pick_b;
                    prio_b_d = !pick_b;
                    mode_d   = pick_b ? MODO_B : MODO_A;
                    dval_d   = pick_b ? D_B : D_A;
                    len_d    = pick_b ? LEN_B : LEN_A;
                    ovf_d    = 1'b0;
                    state_d  = PRELOAD;
                end
            end
            PRELOAD: begin
                CNT_ENABLE = 1'b1;
                CNT_MODO   = MODE_LOAD;
                if (mode_q != MODE_LOAD && len_q != '0) begin
                    state_d = RUN;
                end else begin
                    state_d = SETTLE;
                end
            end
            RUN: begin
                CNT_ENABLE = 1'b1;
                CNT_MODO   = mode_q;
                if (CNT_RCO) begin
                    ovf_d = 1'b1;
                end
                len_d = len_q - LEN_ONE;
                if (len_q == LEN_ONE) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                result_d = CNT_Q;
                state_d  = DONE;
            end
            DONE: begin
                // The served requester sits out the next IDLE cycle
                blk_a_d = !gnt_q;
                blk_b_d = gnt_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            mode_q   <= 2'b00;
            dval_q   <= '0;
            len_q    <= '0;
            gnt_q    <= 1'b0;
            prio_b_q <= 1'b0;
            blk_a_q  <= 1'b0;
            blk_b_q  <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            dval_q   <= dval_d;
            len_q    <= len_d;
            gnt_q    <= gnt_d;
            prio_b_q <= prio_b_d;
            blk_a_q  <= blk_a_d;
            blk_b_q  <= blk_b_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign CNT_D  = dval_q;
    assign ACK_A  = (state_q == DONE) && !gnt_q;
    assign ACK_B  = (state_q == DONE) && gnt_q;
    assign BUSY   = (state_q != IDLE);
    assign GNT    = gnt_q;
    assign RESULT = result_q;
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_counter_sched.sv
// Scoreboard bench for counter_sched driving a behavioural 32-bit counter; stimulus pushes
// hand-computed expectations, a monitor pops and compares them on every ACK.
module tb_counter_sched;

    localparam int LEN_W = 16;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             REQ_A, REQ_B;
    logic [1:0]       MODO_A, MODO_B;
    logic [31:0]      D_A, D_B;
    logic [LEN_W-1:0] LEN_A, LEN_B;
    logic [31:0]      CNT_Q;
    logic             CNT_RCO;
    logic             CNT_ENABLE;
    logic [1:0]       CNT_MODO;
    logic [31:0]      CNT_D;
    logic             ACK_A, ACK_B, BUSY, GNT, OVF;
    logic [31:0]      RESULT;

    always #5 CLK = ~CLK;

    counter_sched #(.LEN_W(LEN_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_A(REQ_A), .REQ_B(REQ_B),
        .MODO_A(MODO_A), .MODO_B(MODO_B),
        .D_A(D_A), .D_B(D_B),
        .LEN_A(LEN_A), .LEN_B(LEN_B),
        .CNT_Q(CNT_Q), .CNT_RCO(CNT_RCO),
        .CNT_ENABLE(CNT_ENABLE), .CNT_MODO(CNT_MODO), .CNT_D(CNT_D),
        .ACK_A(ACK_A), .ACK_B(ACK_B),
        .BUSY(BUSY), .GNT(GNT), .RESULT(RESULT), .OVF(OVF)
    );

    // Behavioural counter: 00 +1, 01 -1, 10 +3, 11 load
    logic [31:0] cnt_m = 32'h0;
    always @(posedge CLK) begin
        if (CNT_ENABLE) begin
            case (CNT_MODO)
                2'b00: cnt_m <= cnt_m + 32'd1;
                2'b01: cnt_m <= cnt_m - 32'd1;
                2'b10: cnt_m <= cnt_m + 32'd3;
                default: cnt_m <= CNT_D;
            endcase
        end
    end
    assign CNT_Q   = cnt_m;
    assign CNT_RCO = CNT_ENABLE && (((CNT_MODO == 2'b00) && (cnt_m == 32'hFFFF_FFFF)) ||
                                    ((CNT_MODO == 2'b10) && (cnt_m > 32'hFFFF_FFFC)) ||
                                    ((CNT_MODO == 2'b01) && (cnt_m == 32'h0)));

    typedef struct {
        logic        is_b;
        logic [31:0] result;
        logic        ovf;
        int          ack_cyc;
        int          en_cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor
    int   en_cnt = 0;
    logic busy_prev = 1'b0;
    always @(negedge CLK) begin
        if (RESET) begin
            en_cnt    = 0;
            busy_prev = 1'b0;
        end else begin
            if (BUSY && !busy_prev) chk("ovf_clear_at_grant", 32'(OVF), 32'h0);
            busy_prev = BUSY;
            if (CNT_ENABLE) en_cnt++;
            if (ACK_A || ACK_B) begin
                chk("ack_exclusive", 32'(ACK_A && ACK_B), 32'h0);
                chk("enable_low_in_done", 32'(CNT_ENABLE), 32'h0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack_a=%0d ack_b=%0d expected none", ACK_A, ACK_B);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_side", 32'(ACK_B), 32'(mon_e.is_b));
                    chk("gnt", 32'(GNT), 32'(mon_e.is_b));
                    chk("result", RESULT, mon_e.result);
                    chk("ovf", 32'(OVF), 32'(mon_e.ovf));
                    chk("ack_cycle", cyc, mon_e.ack_cyc);
                    chk("enable_cycles", en_cnt, mon_e.en_cyc);
                end
                en_cnt = 0;
            end
        end
    end

    task automatic wait_ack(input logic is_b);
        for (int n = 0; n < 70000; n++) begin
            @(negedge CLK);
            if (is_b ? ACK_B : ACK_A) return;
        end
        checks++;
        errors++;
        $display("FAIL ack_timeout: got no ack expected ack_%s", is_b ? "b" : "a");
    endtask

    task automatic drive(input logic is_b, input logic [1:0] mode, input logic [31:0] d,
                         input logic [LEN_W-1:0] len);
        if (is_b) begin
            REQ_B = 1'b1; MODO_B = mode; D_B = d; LEN_B = len;
        end else begin
            REQ_A = 1'b1; MODO_A = mode; D_A = d; LEN_A = len;
        end
    endtask

    task automatic push(input logic is_b, input logic [31:0] res, input logic ovf,
                        input int ack_cyc, input int en);
        exp_t e;
        e.is_b = is_b; e.result = res; e.ovf = ovf; e.ack_cyc = ack_cyc; e.en_cyc = en;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic is_b, input logic [1:0] mode, input logic [31:0] d,
                         input logic [LEN_W-1:0] len, input logic [31:0] res, input logic ovf,
                         input int lat, input int en);
        repeat (2) @(negedge CLK);
        drive(is_b, mode, d, len);
        push(is_b, res, ovf, cyc + lat, en);
        wait_ack(is_b);
        if (is_b) REQ_B = 1'b0; else REQ_A = 1'b0;
    endtask

    initial begin
        int c;
        RESET = 1'b1;
        REQ_A = 1'b0; REQ_B = 1'b0;
        MODO_A = 2'b00; MODO_B = 2'b00;
        D_A = 32'h0; D_B = 32'h0;
        LEN_A = '0; LEN_B = '0;
        repeat (3) @(negedge CLK);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_enable", 32'(CNT_ENABLE), 32'h0);
        chk("rst_modo", 32'(CNT_MODO), 32'h0);
        chk("rst_cnt_d", CNT_D, 32'h0);
        chk("rst_acks", 32'({ACK_A, ACK_B}), 32'h0);
        chk("rst_gnt", 32'(GNT), 32'h0);
        chk("rst_result", RESULT, 32'h0);
        chk("rst_ovf", 32'(OVF), 32'h0);
        RESET = 1'b0;

        issue(1'b0, 2'b00, 32'h0000_0010, 16'd5, 32'h0000_0015, 1'b0, 8, 6);
        issue(1'b1, 2'b11, 32'hDEAD_BEEF, 16'd7, 32'hDEAD_BEEF, 1'b0, 3, 1);
        issue(1'b0, 2'b00, 32'hFFFF_FFFE, 16'd3, 32'h0000_0001, 1'b1, 6, 4);
        issue(1'b0, 2'b10, 32'h0000_0005, 16'd2, 32'h0000_000B, 1'b0, 5, 3);
        issue(1'b0, 2'b01, 32'h0000_0007, 16'd0, 32'h0000_0007, 1'b0, 3, 1);
        issue(1'b0, 2'b01, 32'h0000_0002, 16'd4, 32'hFFFF_FFFE, 1'b1, 7, 5);

        // REQ_B dropped and its fields changed mid-command
        repeat (2) @(negedge CLK);
        c = cyc;
        drive(1'b1, 2'b00, 32'h1, 16'd2);
        push(1'b1, 32'h3, 1'b0, c + 5, 3);
        repeat (2) @(negedge CLK);
        REQ_B = 1'b0; MODO_B = 2'b11; D_B = 32'h999;
        wait_ack(1'b1);

        issue(1'b0, 2'b00, 32'h0, 16'hFFFF, 32'h0000_FFFF, 1'b0, 65538, 65536);

        // Round-robin after a fresh reset: A, B, A
        @(negedge CLK); RESET = 1'b1;
        repeat (2) @(negedge CLK); RESET = 1'b0;
        @(negedge CLK);
        c = cyc;
        drive(1'b0, 2'b00, 32'h100, 16'd1);
        drive(1'b1, 2'b11, 32'h22, 16'd0);
        push(1'b0, 32'h101, 1'b0, c + 4, 2);
        push(1'b1, 32'h22, 1'b0, c + 8, 1);
        wait_ack(1'b0);
        MODO_A = 2'b11; D_A = 32'h300;
        push(1'b0, 32'h300, 1'b0, c + 12, 1);
        wait_ack(1'b1);
        REQ_B = 1'b0;
        wait_ack(1'b0);
        REQ_A = 1'b0;

        // Reset in the third RUN cycle of a LEN=10 command
        repeat (2) @(negedge CLK);
        c = cyc;
        drive(1'b0, 2'b00, 32'h0, 16'd10);
        repeat (4) @(negedge CLK);
        chk("abort_pre_busy", 32'(BUSY), 32'h1);
        chk("abort_pre_enable", 32'(CNT_ENABLE), 32'h1);
        RESET = 1'b1;
        REQ_A = 1'b0;
        @(negedge CLK);
        chk("abort_busy", 32'(BUSY), 32'h0);
        chk("abort_enable", 32'(CNT_ENABLE), 32'h0);
        chk("abort_ack", 32'({ACK_A, ACK_B}), 32'h0);
        chk("abort_result", RESULT, 32'h0);
        chk("abort_cycle", cyc, c + 5);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (20) @(negedge CLK);

        chk("queue_empty", exp_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
